// File: rtl/mips32_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips32_muldiv_pkg
// Brief  : Op codes, FSM state codes and decode funct codes for the MIPS32
//          multiply/divide unit. MIPS32_MADD_EN widens op to 3 bits.
// Rev    : 1.0
// ============================================================================
package mips32_muldiv_pkg;

`ifdef MIPS32_MADD_EN
  localparam int OP_W = 3;
`else
  localparam int OP_W = 2;
`endif

  localparam logic [OP_W-1:0] MD_MULT  = OP_W'(0);
  localparam logic [OP_W-1:0] MD_MULTU = OP_W'(1);
  localparam logic [OP_W-1:0] MD_DIV   = OP_W'(2);
  localparam logic [OP_W-1:0] MD_DIVU  = OP_W'(3);
`ifdef MIPS32_MADD_EN
  localparam logic [OP_W-1:0] MD_MADD  = OP_W'(4);
  localparam logic [OP_W-1:0] MD_MADDU = OP_W'(5);
`endif

  // SPECIAL-opcode funct fields used by the decode glue
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
`ifdef MIPS32_MADD_EN
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD);
`else
    return (op == MD_MULT) || (op == MD_DIV);
`endif
  endfunction

`ifdef MIPS32_MADD_EN
  function automatic logic op_is_madd(input logic [OP_W-1:0] op);
    return (op == MD_MADD) || (op == MD_MADDU);
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/mips32_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module : mips32_muldiv_if
// Brief  : EX-stage request / HI-LO result bundle for the multiply/divide unit.
// Rev    : 1.0
// ============================================================================
interface mips32_muldiv_if #(
  parameter int DATA_W = 32
);
  import mips32_muldiv_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              kill;
  logic              mthi_we;
  logic              mtlo_we;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output in_valid, op, rs_val, rt_val, kill, mthi_we, mtlo_we, wdata,
    input  in_ready, busy, done, hi, lo
  );

  modport slave (
    input  in_valid, op, rs_val, rt_val, kill, mthi_we, mtlo_we, wdata,
    output in_ready, busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mips32_muldiv_sign_cond.sv
`default_nettype none
// ============================================================================
// Module : mips32_muldiv_sign_cond
// Brief  : Conditional two's-complement negate (abs on entry, sign fix on exit).
// Rev    : 1.0
// ============================================================================
module mips32_muldiv_sign_cond #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_data
);
  assign o_data = i_neg ? (~i_data + 1'b1) : i_data;
endmodule
`default_nettype wire

// File: rtl/mips32_muldiv.sv
`default_nettype none
// ============================================================================
// Module : mips32_muldiv
// Brief  : Radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO; MIPS32_MADD_EN adds
//          MADD/MADDU accumulate into {HI,LO}.
// Rev    : 1.0
// ============================================================================
module mips32_muldiv
  import mips32_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic           clk1,
  input  logic           rst,
  mips32_muldiv_if.slave md
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam int ACC_W = 2 * DATA_W;

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              div0_q, div0_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;

  logic              w_accept, w_in_div, w_in_sgn, w_neg_rs, w_neg_rt;
  logic [DATA_W-1:0] w_mag_rs, w_mag_rt, w_quo_fix, w_rem_fix, w_div_diff;
  logic [DATA_W:0]   w_mul_sum, w_div_rem;
  logic              w_div_ge;
  logic [ACC_W-1:0]  w_mul_step, w_div_step, w_prod_fix;

  assign w_accept = md.in_valid & md.in_ready & ~md.kill;
  assign w_in_div = op_is_div(md.op);
  assign w_in_sgn = op_is_signed(md.op);
  assign w_neg_rs = w_in_sgn & md.rs_val[DATA_W-1];
  assign w_neg_rt = w_in_sgn & md.rt_val[DATA_W-1];

  mips32_muldiv_sign_cond #(.WIDTH(DATA_W)) u_abs_rs (
    .i_data(md.rs_val), .i_neg(w_neg_rs), .o_data(w_mag_rs));
  mips32_muldiv_sign_cond #(.WIDTH(DATA_W)) u_abs_rt (
    .i_data(md.rt_val), .i_neg(w_neg_rt), .o_data(w_mag_rt));

  // Multiply: multiplier sits in the low half and is consumed LSB first.
  assign w_mul_sum  = {1'b0, acc_q[ACC_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign w_mul_step = {w_mul_sum, acc_q[DATA_W-1:1]};

  // Divide: partial remainder in the high half, quotient bits enter at the bottom.
  assign w_div_rem  = acc_q[ACC_W-1:DATA_W-1];
  assign w_div_ge   = (w_div_rem >= {1'b0, opnd_q});
  assign w_div_diff = w_div_rem[DATA_W-1:0] - opnd_q;
  assign w_div_step = w_div_ge ? {w_div_diff, acc_q[DATA_W-2:0], 1'b1}
                               : {w_div_rem[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};

  mips32_muldiv_sign_cond #(.WIDTH(ACC_W)) u_fix_prod (
    .i_data(acc_q), .i_neg(neg_a_q ^ neg_b_q), .o_data(w_prod_fix));
  mips32_muldiv_sign_cond #(.WIDTH(DATA_W)) u_fix_quo (
    .i_data(acc_q[DATA_W-1:0]), .i_neg(neg_a_q ^ neg_b_q), .o_data(w_quo_fix));
  mips32_muldiv_sign_cond #(.WIDTH(DATA_W)) u_fix_rem (
    .i_data(acc_q[ACC_W-1:DATA_W]), .i_neg(neg_a_q), .o_data(w_rem_fix));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (md.mthi_we) hi_d = md.wdata;
        if (md.mtlo_we) lo_d = md.wdata;
        if (w_accept) begin
          op_d    = md.op;
          neg_a_d = w_neg_rs;
          neg_b_d = w_neg_rt;
          count_d = '0;
          div0_d  = w_in_div && (md.rt_val == '0);
          opnd_d  = w_in_div ? w_mag_rt : w_mag_rs;
          if (w_in_div && (md.rt_val == '0)) begin
            acc_d   = {md.rs_val, {DATA_W{1'b1}}};
            state_d = ST_FIX;
          end else begin
            acc_d   = {{DATA_W{1'b0}}, (w_in_div ? w_mag_rs : w_mag_rt)};
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d   = op_is_div(op_q) ? w_div_step : w_mul_step;
        count_d = count_q + 1'b1;
        if (count_q == CNT_W'(DATA_W - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (div0_q) begin
          {hi_d, lo_d} = acc_q;
        end else if (op_is_div(op_q)) begin
          hi_d = w_rem_fix;
          lo_d = w_quo_fix;
        end
`ifdef MIPS32_MADD_EN
        else if (op_is_madd(op_q)) begin
          {hi_d, lo_d} = {hi_q, lo_q} + w_prod_fix;
        end
`endif
        else begin
          {hi_d, lo_d} = w_prod_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A flush abandons the op without touching HI/LO or raising done.
    if (md.kill && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign md.in_ready = (state_q == ST_IDLE);
  assign md.busy     = (state_q != ST_IDLE);
  assign md.done     = done_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_mips32_muldiv.sv
`default_nettype none
// ============================================================================
// Module : tb_mips32_muldiv
// Brief  : Directed + random bench for mips32_muldiv against an arithmetic model.
// Rev    : 1.0
// ============================================================================
module tb_mips32_muldiv;
  import mips32_muldiv_pkg::*;

  localparam int DW = 32;

  logic clk1;
  logic rst;
  int   checks;
  int   passed;
  logic [31:0] mhi, mlo;

  mips32_muldiv_if #(.DATA_W(DW)) m ();

  mips32_muldiv #(.DATA_W(DW)) dut (
    .clk1(clk1),
    .rst (rst),
    .md  (m)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Architectural result of one op as {HI, LO}, from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [OP_W-1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur, res;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = acc;
    if (op == MD_MULT) res = sa * sb;
    else if (op == MD_MULTU) res = ua * ub;
    else if (op == MD_DIV || op == MD_DIVU) begin
      if (b == 32'd0) res = {a, 32'hffff_ffff};
      else if (op == MD_DIV) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end else begin
        uq = ua / ub;
        ur = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
    end
`ifdef MIPS32_MADD_EN
    else if (op == MD_MADD) res = acc + 64'(sa * sb);
    else if (op == MD_MADDU) res = acc + ua * ub;
`endif
    return res;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the unit idle (or in its done cycle).
  task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int kill_at, input int mthi_at);
    logic [63:0] exp;
    int          lat, exp_lat;
    bit          seen;
    exp     = ref_md(op, a, b, {mhi, mlo});
    exp_lat = ((op == MD_DIV || op == MD_DIVU) && b == 32'd0) ? 1 : DW + 1;
    m.in_valid = 1'b1;
    m.op       = op;
    m.rs_val   = a;
    m.rt_val   = b;
    @(negedge clk1);
    m.in_valid = 1'b0;
    m.rs_val   = $urandom;
    m.rt_val   = $urandom;
    check("busy_after_accept", m.busy, 1);
    check("in_ready_while_busy", m.in_ready, 0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 3 * DW) begin
      if (m.done === 1'b1) seen = 1'b1;
      else begin
        m.kill    = (lat == kill_at);
        m.mthi_we = (lat == mthi_at);
        m.wdata   = 32'h0000_1234;
        @(negedge clk1);
        m.kill    = 1'b0;
        m.mthi_we = 1'b0;
        lat++;
        if (kill_at >= 0 && lat == kill_at + 1) begin
          check("in_ready_after_kill", m.in_ready, 1);
          check("busy_after_kill", m.busy, 0);
        end
      end
    end
    if (kill_at >= 0) check("no_done_after_kill", seen, 0);
    else begin
      check("done_seen", seen, 1);
      check("latency", lat, exp_lat);
      mhi = exp[63:32];
      mlo = exp[31:0];
    end
    check("hi", m.hi, mhi);
    check("lo", m.lo, mlo);
  endtask

  initial begin
    checks    = 0;
    passed    = 0;
    mhi       = '0;
    mlo       = '0;
    rst       = 1'b1;
    m.in_valid = 1'b0;
    m.op       = MD_MULT;
    m.rs_val   = '0;
    m.rt_val   = '0;
    m.kill     = 1'b0;
    m.mthi_we  = 1'b0;
    m.mtlo_we  = 1'b0;
    m.wdata    = '0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    rst = 1'b0;
    check("reset_hi", m.hi, 0);
    check("reset_lo", m.lo, 0);
    check("reset_busy", m.busy, 0);
    check("reset_done", m.done, 0);
    check("reset_in_ready", m.in_ready, 1);

    issue(MD_MULTU, 32'hffff_ffff, 32'h0000_0002, -1, -1);
    check("multu_hi_const", m.hi, 32'h0000_0001);
    check("multu_lo_const", m.lo, 32'hffff_fffe);
    issue(MD_MULT, 32'hffff_fffd, 32'h0000_0007, -1, -1);
    issue(MD_DIV, 32'hffff_fff9, 32'h0000_0002, -1, -1);
    check("div_lo_const", m.lo, 32'hffff_fffd);
    issue(MD_DIVU, 32'h0000_0064, 32'h0000_0000, -1, -1);
    issue(MD_DIV, 32'h8000_0000, 32'hffff_ffff, -1, -1);
    issue(MD_DIV, 32'h8000_0000, 32'h0000_0000, -1, -1);

    // MTHI while busy must be dropped; kill then keeps the pre-op HI/LO.
    issue(MD_MULTU, $urandom, $urandom, 10, 5);

    m.in_valid = 1'b1;
    m.kill     = 1'b1;
    m.op       = MD_MULTU;
    m.rs_val   = 32'd3;
    m.rt_val   = 32'd3;
    @(negedge clk1);
    m.in_valid = 1'b0;
    m.kill     = 1'b0;
    check("kill_idle_not_busy", m.busy, 0);
    check("kill_idle_in_ready", m.in_ready, 1);
    repeat (DW + 4) @(negedge clk1);
    check("kill_idle_hi", m.hi, mhi);
    check("kill_idle_lo", m.lo, mlo);

    m.mtlo_we = 1'b1;
    m.wdata   = 32'h0000_0055;
    @(negedge clk1);
    m.mtlo_we = 1'b0;
    mlo = 32'h0000_0055;
    check("mtlo_lo", m.lo, mlo);
    check("mtlo_hi", m.hi, mhi);

`ifdef MIPS32_MADD_EN
    m.mthi_we = 1'b1;
    m.wdata   = 32'h0000_0000;
    @(negedge clk1);
    m.mthi_we = 1'b0;
    m.mtlo_we = 1'b1;
    m.wdata   = 32'hffff_ffff;
    @(negedge clk1);
    m.mtlo_we = 1'b0;
    mhi = 32'h0;
    mlo = 32'hffff_ffff;
    issue(MD_MADD, 32'd1, 32'd1, -1, -1);
    check("madd_hi_const", m.hi, 32'h1);
    check("madd_lo_const", m.lo, 32'h0);
    issue(MD_MADD, $urandom, 32'hffff_fff0, 18, -1);
`endif

    for (int i = 0; i < 24; i++) begin
`ifdef MIPS32_MADD_EN
      issue(OP_W'($urandom_range(0, 5)), pick(), pick(), -1, -1);
`else
      issue(OP_W'($urandom_range(0, 3)), pick(), pick(), -1, -1);
`endif
      if ($urandom_range(0, 2) == 0) @(negedge clk1);
    end

    m.in_valid = 1'b1;
    m.op       = MD_MULTU;
    m.rs_val   = 32'hdead_beef;
    m.rt_val   = 32'h0000_1235;
    @(negedge clk1);
    m.in_valid = 1'b0;
    repeat (6) @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    mhi = '0;
    mlo = '0;
    check("rst_mid_hi", m.hi, 0);
    check("rst_mid_lo", m.lo, 0);
    check("rst_mid_busy", m.busy, 0);
    check("rst_mid_done", m.done, 0);
    issue(MD_DIVU, 32'h0001_0000, 32'h0000_0007, -1, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
